// File: rtl/ldpc_pkg.sv
// Shared types and helpers for the layered LDPC scheduler: null-shift encoding,
// FSM state encoding and the inverse-shift mapping used on the scatter pass.
package ldpc_pkg;

  localparam int unsigned MTX_W = 8;

  typedef logic [MTX_W-1:0] shift_t;

  // All-ones marks a null (zero) sub-matrix; the shifter treats it as neutral.
  localparam shift_t NULL_SHIFT = '1;

  typedef enum logic [2:0] {
    StIdle,
    StGather,
    StCnuWait,
    StScatter,
    StIterEnd,
    StDone
  } state_e;

  function automatic shift_t inv_shift(input shift_t s, input int unsigned d);
    shift_t r;
    if (s == '0) begin
      r = '0;
    end else if (s == NULL_SHIFT) begin
      r = NULL_SHIFT;
    end else begin
      r = shift_t'(d) - s;
    end
    return r;
  endfunction

endpackage

// File: rtl/ldpc_layer_sched_if.sv
// Bundle between the layer scheduler and its surroundings: base-matrix memory,
// cyclic shifter, check-node unit and decoder control.
interface ldpc_layer_sched_if #(
  parameter int unsigned mtx_w  = 8,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned ITER_W = 6,
  parameter int unsigned COL_W  = 3,
  parameter int unsigned ROW_W  = 2
);

  logic              start;
  logic [ITER_W-1:0] iter_limit;
  logic              hm_rd;
  logic [ADDR_W-1:0] hm_addr;
  logic [mtx_w-1:0]  hm_data;
  logic [mtx_w-1:0]  shift;
  logic              gth_valid;
  logic              sct_valid;
  logic [COL_W-1:0]  col_idx;
  logic [ROW_W-1:0]  layer_idx;
  logic              cnu_start;
  logic              cnu_done;
  logic              synd_ok;
  logic              busy;
  logic              done;
  logic              converged;
  logic [ITER_W-1:0] iter_cnt;
  logic              cfg_err;

  modport master (
    input  start, iter_limit, hm_data, cnu_done, synd_ok,
    output hm_rd, hm_addr, shift, gth_valid, sct_valid, col_idx, layer_idx,
           cnu_start, busy, done, converged, iter_cnt, cfg_err
  );

  modport slave (
    output start, iter_limit, hm_data, cnu_done, synd_ok,
    input  hm_rd, hm_addr, shift, gth_valid, sct_valid, col_idx, layer_idx,
           cnu_start, busy, done, converged, iter_cnt, cfg_err
  );

endinterface

// File: rtl/ldpc_shift_cache.sv
// Per-layer cache of sanitised shift values: filled during gather, replayed on scatter.
// One write port, one combinational read port.
module ldpc_shift_cache #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 8,
  parameter int unsigned AddrW = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '1;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Reads past the last column return the null value instead of an undefined entry.
  assign rdata_o = (32'(raddr_i) < Depth) ? mem_q[raddr_i] : '1;

endmodule

// File: rtl/ldpc_layer_sched.sv
// Layered-decoding scheduler: per layer streams shifts to the shifter (gather), waits
// for the CNU, replays inverse shifts (scatter); counts iterations until syndrome/limit.
module ldpc_layer_sched
  import ldpc_pkg::*;
#(
  parameter int unsigned mtx_w  = MTX_W,
  parameter int unsigned D      = 5,
  parameter int unsigned ROWS   = 4,
  parameter int unsigned COLS   = 8,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned ITER_W = 6
) (
  input logic                clk,
  input logic                rst,
  ldpc_layer_sched_if.master bus
);

  localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CNT_W = $clog2(COLS + 3);

  localparam logic [mtx_w-1:0]  D_V    = mtx_w'(D);
  localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(COLS);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ROW_W-1:0]  layer_q, layer_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [ITER_W-1:0] limit_q, limit_d;
  logic              conv_q, conv_d;
  logic              cnu_start_q, cnu_start_d;
  logic              clr_err;

  logic              hm_rd;
  logic              sct_issue;
  logic              rd_q;
  logic [COL_W-1:0]  rcol_q;
  logic [mtx_w-1:0]  shift_q;
  logic              gth_q, sct_q;
  logic [COL_W-1:0]  col_q;
  logic              err_q;

  logic              fetch_bad;
  logic [mtx_w-1:0]  fetch_s;
  logic [mtx_w-1:0]  cache_rd;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      layer_q     <= '0;
      iter_q      <= '0;
      limit_q     <= '0;
      conv_q      <= 1'b0;
      cnu_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      layer_q     <= layer_d;
      iter_q      <= iter_d;
      limit_q     <= limit_d;
      conv_q      <= conv_d;
      cnu_start_q <= cnu_start_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    layer_d     = layer_q;
    iter_d      = iter_q;
    limit_d     = limit_q;
    conv_d      = conv_q;
    cnu_start_d = 1'b0;
    clr_err     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StGather;
          cnt_d   = '0;
          layer_d = '0;
          iter_d  = '0;
          conv_d  = 1'b0;
          clr_err = 1'b1;
          limit_d = (bus.iter_limit == '0) ? ITER_W'(1) : bus.iter_limit;
        end
      end
      StGather: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Two extra cycles drain the memory read and shift register stages.
        if (cnt_q == CNT_W'(COLS + 1)) begin
          state_d     = StCnuWait;
          cnt_d       = '0;
          cnu_start_d = 1'b1;
        end
      end
      StCnuWait: begin
        if (bus.cnu_done) begin
          state_d = StScatter;
          cnt_d   = '0;
        end
      end
      StScatter: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(COLS)) begin
          cnt_d = '0;
          if (layer_q == ROW_W'(ROWS - 1)) begin
            state_d = StIterEnd;
          end else begin
            layer_d = layer_q + ROW_W'(1);
            state_d = StGather;
          end
        end
      end
      StIterEnd: begin
        iter_d = iter_q + ITER_W'(1);
        if (bus.synd_ok) begin
          conv_d  = 1'b1;
          state_d = StDone;
        end else if ((iter_q + ITER_W'(1)) == limit_q) begin
          state_d = StDone;
        end else begin
          layer_d = '0;
          cnt_d   = '0;
          state_d = StGather;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shift datapath
  // ---------------------------------------------------------------------------
  assign hm_rd     = (state_q == StGather) && (cnt_q < CNT_W'(COLS));
  assign sct_issue = (state_q == StScatter) && (cnt_q < CNT_W'(COLS));

  // Out-of-range shifts are forced to null so the shifter never sees an illegal rotation.
  assign fetch_bad = (bus.hm_data != NULL_SHIFT) && (bus.hm_data >= D_V);
  assign fetch_s   = fetch_bad ? NULL_SHIFT : bus.hm_data;

  ldpc_shift_cache #(
    .Depth (COLS),
    .Width (mtx_w),
    .AddrW (COL_W)
  ) u_cache (
    .clk     (clk),
    .rst     (rst),
    .we_i    (rd_q),
    .waddr_i (rcol_q),
    .wdata_i (fetch_s),
    .raddr_i (cnt_q[COL_W-1:0]),
    .rdata_o (cache_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q    <= 1'b0;
      rcol_q  <= '0;
      shift_q <= '0;
      gth_q   <= 1'b0;
      sct_q   <= 1'b0;
      col_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      rd_q   <= hm_rd;
      rcol_q <= cnt_q[COL_W-1:0];
      gth_q  <= 1'b0;
      sct_q  <= 1'b0;
      if (rd_q) begin
        shift_q <= fetch_s;
        gth_q   <= 1'b1;
        col_q   <= rcol_q;
      end else if (sct_issue) begin
        shift_q <= inv_shift(cache_rd, D);
        sct_q   <= 1'b1;
        col_q   <= cnt_q[COL_W-1:0];
      end
      if (clr_err) begin
        err_q <= 1'b0;
      end else if (rd_q && fetch_bad) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.hm_rd     = hm_rd;
  assign bus.hm_addr   = hm_rd ? (ADDR_W'(layer_q) * COLS_A + ADDR_W'(cnt_q)) : '0;
  assign bus.shift     = shift_q;
  assign bus.gth_valid = gth_q;
  assign bus.sct_valid = sct_q;
  assign bus.col_idx   = col_q;
  assign bus.layer_idx = layer_q;
  assign bus.cnu_start = cnu_start_q;
  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = (state_q == StDone);
  assign bus.converged = conv_q;
  assign bus.iter_cnt  = iter_q;
  assign bus.cfg_err   = err_q;

endmodule

// File: tb/tb_ldpc_layer_sched.sv
// Directed bench for ldpc_layer_sched (D=5, 2 layers x 3 columns) with a scoreboard
// of expected addresses, gather beats and scatter beats.
module tb_ldpc_layer_sched;

  localparam int unsigned MW = 8;
  localparam int unsigned DD = 5;
  localparam int unsigned NR = 2;
  localparam int unsigned NC = 3;
  localparam int unsigned AW = 5;
  localparam int unsigned IW = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ldpc_layer_sched_if #(.mtx_w(MW), .ADDR_W(AW), .ITER_W(IW), .COL_W(2), .ROW_W(1)) bus ();

  ldpc_layer_sched #(
    .mtx_w  (MW),
    .D      (DD),
    .ROWS   (NR),
    .COLS   (NC),
    .ADDR_W (AW),
    .ITER_W (IW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [7:0] s;
    logic [1:0] c;
    logic       l;
  } beat_t;

  beat_t gq[$];
  beat_t sq[$];
  int    aq[$];

  int total = 0;
  int bad   = 0;

  logic [7:0] hmem  [6];
  logic [7:0] g_exp [2][3];
  logic [7:0] s_exp [2][3];

  int   cnu_delay = 0;
  logic stray     = 1'b0;
  int   last_wait = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs_vec();
    return {2'b0, bus.hm_rd, bus.hm_addr, bus.shift, bus.gth_valid, bus.sct_valid,
            bus.col_idx, bus.layer_idx, bus.cnu_start, bus.busy, bus.done,
            bus.converged, bus.iter_cnt, bus.cfg_err};
  endfunction

  task automatic push_decode(input int iters);
    for (int it = 0; it < iters; it++) begin
      for (int l = 0; l < 2; l++) begin
        for (int c = 0; c < 3; c++) begin
          aq.push_back(l * 3 + c);
          gq.push_back('{s: g_exp[l][c], c: 2'(c), l: 1'(l)});
          sq.push_back('{s: s_exp[l][c], c: 2'(c), l: 1'(l)});
        end
      end
    end
  endtask

  task automatic start_dec(input logic [5:0] lim, input int iters);
    push_decode(iters);
    @(posedge clk); #1;
    bus.iter_limit = lim;
    bus.start      = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("start_state", {28'b0, bus.busy, bus.converged, bus.cfg_err, |bus.iter_cnt}, 32'h8);
  endtask

  task automatic finish_dec(input logic [5:0] it, input logic conv, input logic err);
    int n = 0;
    while (!bus.done && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", bus.done, 1);
    chk("iter_cnt", bus.iter_cnt, it);
    chk("converged", bus.converged, conv);
    chk("cfg_err", bus.cfg_err, err);
    @(negedge clk);
    chk("busy_after_done", bus.busy, 0);
    chk("done_one_cycle", bus.done, 0);
    chk("converged_hold", bus.converged, conv);
    chk("addr_left", aq.size(), 0);
    chk("gather_left", gq.size(), 0);
    chk("scatter_left", sq.size(), 0);
  endtask

  // Base-matrix memory: data valid one cycle after the read strobe.
  initial begin
    logic       rd_s;
    logic [4:0] a_s;
    bus.hm_data = '0;
    forever begin
      @(negedge clk);
      rd_s = bus.hm_rd;
      a_s  = bus.hm_addr;
      @(posedge clk); #1;
      if (rd_s) bus.hm_data = (a_s < 5'd6) ? hmem[a_s] : 8'hEE;
    end
  end

  // CNU model: answers cnu_start after cnu_delay cycles; optional stray pulse during gather.
  initial begin
    bus.cnu_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst && bus.cnu_start) begin
        repeat (cnu_delay) begin
          @(posedge clk); #1;
        end
        bus.cnu_done = 1'b1;
        @(posedge clk); #1;
        bus.cnu_done = 1'b0;
      end else if (!rst && stray && bus.gth_valid) begin
        stray        = 1'b0;
        bus.cnu_done = 1'b1;
        @(posedge clk); #1;
        bus.cnu_done = 1'b0;
      end
    end
  end

  // Output monitor: pops the scoreboard and checks handshake timing.
  initial begin
    logic last_gth = 1'b0;
    logic waiting  = 1'b0;
    int   sct_due  = -1;
    int   wait_len = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        last_gth = 1'b0;
        waiting  = 1'b0;
        sct_due  = -1;
      end else begin
        chk("valid_exclusive", {31'b0, bus.gth_valid & bus.sct_valid}, 0);
        if (bus.hm_rd) begin
          chk("addr_expected", aq.size() != 0, 1);
          if (aq.size() != 0) chk("hm_addr", bus.hm_addr, aq.pop_front());
        end
        if (bus.gth_valid) begin
          chk("gather_expected", gq.size() != 0, 1);
          if (gq.size() != 0) chk("gather_beat", {bus.shift, bus.col_idx, bus.layer_idx},
                                  gq.pop_front());
        end
        if (bus.sct_valid) begin
          chk("scatter_expected", sq.size() != 0, 1);
          if (sq.size() != 0) chk("scatter_beat", {bus.shift, bus.col_idx, bus.layer_idx},
                                  sq.pop_front());
        end
        chk("cnu_start", bus.cnu_start, last_gth);
        last_gth = bus.gth_valid && (bus.col_idx == 2'd2);
        if (sct_due == 0) begin
          chk("scatter_latency", bus.sct_valid, 1);
          sct_due = -1;
        end else if (sct_due > 0) begin
          chk("scatter_early", bus.sct_valid, 0);
          sct_due--;
        end
        if (waiting) chk("scatter_in_wait", bus.sct_valid, 0);
        if (bus.cnu_start) begin
          waiting  = 1'b1;
          wait_len = 0;
        end else if (waiting) begin
          wait_len++;
        end
        if (waiting && bus.cnu_done) begin
          waiting   = 1'b0;
          sct_due   = 1;
          last_wait = wait_len;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int n;
    hmem  = '{8'h02, 8'hFF, 8'h00, 8'h04, 8'h01, 8'h07};
    g_exp = '{'{8'h02, 8'hFF, 8'h00}, '{8'h04, 8'h01, 8'hFF}};
    s_exp = '{'{8'h03, 8'hFF, 8'h00}, '{8'h01, 8'h04, 8'hFF}};

    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.iter_limit = '0;
    bus.synd_ok    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", outs_vec(), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single iteration, limit 1.
    start_dec(6'd1, 1);
    finish_dec(6'd1, 1'b0, 1'b1);

    // Early termination on syndrome.
    bus.synd_ok = 1'b1;
    start_dec(6'd10, 1);
    finish_dec(6'd1, 1'b1, 1'b1);
    bus.synd_ok = 1'b0;

    // CNU stall plus stray cnu_done during gather.
    cnu_delay = 7;
    stray     = 1'b1;
    start_dec(6'd1, 1);
    finish_dec(6'd1, 1'b0, 1'b1);
    chk("stall_length", last_wait, 7);
    cnu_delay = 0;

    // Limit 0 behaves as 1; limit 3 runs three iterations.
    start_dec(6'd0, 1);
    finish_dec(6'd1, 1'b0, 1'b1);
    start_dec(6'd3, 3);
    finish_dec(6'd3, 1'b0, 1'b1);

    // Start while busy is ignored.
    start_dec(6'd1, 1);
    repeat (4) @(posedge clk);
    #1;
    bus.iter_limit = 6'd3;
    bus.start      = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    finish_dec(6'd1, 1'b0, 1'b1);

    // Reset during scatter.
    start_dec(6'd1, 1);
    n = 0;
    while (!bus.sct_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("scatter_reached", bus.sct_valid, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_reset_outputs", outs_vec(), 0);
    aq.delete();
    gq.delete();
    sq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_reset_idle", {30'b0, bus.busy, bus.done}, 0);
    end

    // Fresh decode after reset.
    start_dec(6'd1, 1);
    finish_dec(6'd1, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ldpc_layer_sched.md
Name: ldpc_layer_sched

Overview:
- Layered-decoding scheduler for the QC-LDPC decoder; sequences the cyclic shifter, one base-matrix row (layer) at a time.
- Per layer: fetches each column's shift value from the base-matrix memory and streams it to the shifter for the gather (VNU->CNU) pass. Handshakes with the check-node unit, then replays cached shifts as inverse shifts for the scatter (CNU->VNU) pass.
- Counts iterations and stops on syndrome pass or iteration limit.

Parameters:
- mtx_w, 8, shift-value width; all-ones value = null (zero) sub-matrix
- D, 5, circulant size; legal shift values 0..D-1
- ROWS, 4, base-matrix rows (layers)
- COLS, 8, base-matrix columns
- ADDR_W, 5, base-matrix address width, >= clog2(ROWS*COLS)
- ITER_W, 6, iteration counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin decode; ignored unless idle
- iter_limit  in  ITER_W  max iterations; sampled at start; 0 treated as 1
- hm_rd  out  1  base-matrix read strobe
- hm_addr  out  ADDR_W  read address = layer*COLS + col
- hm_data  in  mtx_w  read data, valid exactly 1 cycle after hm_rd
- shift  out  mtx_w  shift value to cyclic shifter
- gth_valid  out  1  shift/col_idx valid for gather pass
- sct_valid  out  1  shift/col_idx valid for scatter pass
- col_idx  out  clog2(COLS)  column of current shift beat
- layer_idx  out  clog2(ROWS)  current layer
- cnu_start  out  1  one-cycle pulse: gather of layer complete
- cnu_done  in  1  CNU finished layer; may be high any cycle
- synd_ok  in  1  all parity checks satisfied; sampled at end of iteration
- busy  out  1  high from accepted start to done
- done  out  1  one-cycle pulse at decode end
- converged  out  1  set with done if synd_ok; held until next accepted start
- iter_cnt  out  ITER_W  iterations completed
- cfg_err  out  1  sticky: shift in D..all-ones-1 seen; cleared on start

Behaviour:
- Reset: all outputs 0, FSM IDLE, counters 0, row cache all-ones.
- FSM states: IDLE, GATHER, CNU_WAIT, SCATTER, ITER_END, DONE.
- IDLE -> GATHER on start (busy=1, layer=0, iter_cnt=0, converged/cfg_err cleared). Start while busy is ignored.
- GATHER issues hm_rd for col 0..COLS-1 on consecutive cycles. hm_data is registered onto shift, so shift has 2-cycle latency from address; gth_valid is high for exactly COLS consecutive cycles.
- Each gather beat also writes cache[col].
- Null handling:
  - hm_data == all-ones passes through unchanged, so the shifter emits its neutral value.
  - Values >= D that are not all-ones are output as all-ones and set cfg_err.
- cnu_start pulses the cycle after the last gth_valid; FSM enters CNU_WAIT.
- CNU_WAIT -> SCATTER on the first cycle cnu_done=1 while in CNU_WAIT. cnu_done outside CNU_WAIT is ignored.
- SCATTER: COLS consecutive sct_valid beats, one cycle after entry, col 0..COLS-1 from cache.
- Inverse shift: s==0 -> 0; all-ones -> all-ones; else D-s (mtx_w-bit unsigned, no wrap).
- After the last scatter beat:
  - if layer < ROWS-1: layer++, -> GATHER;
  - else -> ITER_END.
- ITER_END (1 cycle): iter_cnt++. Then:
  - if synd_ok: converged=1, -> DONE;
  - else if iter_cnt (new) == limit: -> DONE;
  - else layer=0, -> GATHER.
- DONE (1 cycle): done=1, busy=0 the following cycle, -> IDLE.
- gth_valid and sct_valid are never high together. shift holds its last value when neither is valid.
- rst mid-operation: immediate return to reset state next cycle; no done pulse.

Decomposition:
- Shared package ldpc_pkg:
  - null-shift constant (all-ones of mtx_w);
  - FSM state enum;
  - function inv_shift(s, D).
- Natural sub-module: ldpc_shift_cache (COLS x mtx_w register file, 1 write port, 1 read port, combinational read).

Test Plan:
- All cases use D=5, ROWS=2, COLS=3, row0={2,FF,0}, row1={4,1,7}.
- Single iteration, limit=1, synd_ok=0:
  - gather shifts 2,FF,0 then scatter 3,FF,0 (layer 0);
  - gather 4,1,FF then scatter 1,4,FF (layer 1);
  - cfg_err=1, done with iter_cnt=1, converged=0.
- Early termination: limit=10, synd_ok=1 at first ITER_END -> done after 1 iteration, converged=1, iter_cnt=1.
- CNU stall: hold cnu_done low 7 cycles after cnu_start -> no sct_valid during wait; scatter starts 1 cycle after cnu_done; a stray cnu_done during GATHER is ignored.
- Limit=0 and limit=3 with synd_ok=0 -> done with iter_cnt=1 and 3 respectively; hm_addr sequence 0,1,2,3,4,5 repeats per iteration.
- Start while busy ignored; rst asserted mid-SCATTER -> next cycle all outputs 0, IDLE; fresh start decodes normally from layer 0.
